// File: rtl/fanout_fork_ctrl.sv
// Eager fork controller: offers one upstream token to every selected consumer,
// tracks per-consumer delivery, and keeps saturating token/stall counters.
module fanout_fork_ctrl #(
  parameter int N_OUT = 9,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_OUT-1:0] en,
  input  logic [N_OUT-1:0] sel,
  output logic [N_OUT-1:0] out_valid,
  input  logic [N_OUT-1:0] out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] tok_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             partial
);

  typedef enum logic {
    IDLE    = 1'b0,
    PARTIAL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [N_OUT-1:0] tgt;
  logic [N_OUT-1:0] done;
  logic [N_OUT-1:0] done_nxt;
  logic [N_OUT-1:0] pend;
  logic [N_OUT-1:0] acc;
  logic             live;
  logic             fire;
  logic             stall;

  // Reset is folded in so the outputs go quiet the moment reset asserts.
  assign live      = ~flush & ~ASYNCRESET;
  assign tgt       = en & sel;
  // done bits of deselected consumers are masked out here, so they never block.
  assign pend      = tgt & ~done;
  assign out_valid = {N_OUT{in_valid & live}} & pend;
  assign in_ready  = live & (&(~pend | out_ready));
  assign acc       = out_valid & out_ready;
  assign fire      = in_valid & in_ready;
  assign stall     = in_valid & ~in_ready & ~flush;

  always_comb begin
    // NOTE: default first so every path assigns done_nxt and no latch is inferred.
    done_nxt = done;
    if (flush || fire) begin
      done_nxt = '0;
    end else if (in_valid) begin
      done_nxt = done | acc;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      done      <= '0;
      state     <= IDLE;
      partial   <= 1'b0;
      tok_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= done_nxt;

      if (fire && tok_cnt != CNT_MAX) begin
        tok_cnt <= tok_cnt + CNT_W'(1);
      end
      if (stall && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (in_valid && !in_ready && (|acc)) begin
            state   <= PARTIAL;
            partial <= 1'b1;
          end
        end
        PARTIAL: begin
          if (fire || flush) begin
            state   <= IDLE;
            partial <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Scenario bench for fanout_fork_ctrl: per-cycle expectations go through a
// scoreboard queue drained on the falling edge; counters are checked inline.
module tb_fanout_fork_ctrl;

  localparam int N = 9;

  typedef struct {
    logic [N-1:0] ov;
    logic         ir;
    logic         part;
  } exp_t;

  logic         CLK = 1'b0;
  logic         ASYNCRESET;
  logic         in_valid;
  logic         flush;
  logic [N-1:0] en;
  logic [N-1:0] sel;
  logic [N-1:0] out_ready;

  logic [N-1:0] out_valid;
  logic         in_ready;
  logic [15:0]  tok_cnt;
  logic [15:0]  stall_cnt;
  logic         partial;

  logic [N-1:0] out_valid_s;
  logic         in_ready_s;
  logic [3:0]   tok_cnt_s;
  logic [3:0]   stall_cnt_s;
  logic         partial_s;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 CLK = ~CLK;

  fanout_fork_ctrl #(.N_OUT(N), .CNT_W(16)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .in_valid(in_valid), .in_ready(in_ready),
    .en(en), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .tok_cnt(tok_cnt), .stall_cnt(stall_cnt), .partial(partial)
  );

  fanout_fork_ctrl #(.N_OUT(N), .CNT_W(4)) dut_sat (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .in_valid(in_valid), .in_ready(in_ready_s),
    .en(en), .sel(sel), .out_valid(out_valid_s), .out_ready(out_ready),
    .flush(flush), .tok_cnt(tok_cnt_s), .stall_cnt(stall_cnt_s), .partial(partial_s)
  );

  // Scoreboard drain: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests_run += 4;
      if (out_valid !== e.ov) begin
        tests_failed++;
        $display("FAIL out_valid @%0t: got %h expected %h", $time, out_valid, e.ov);
      end
      if (in_ready !== e.ir) begin
        tests_failed++;
        $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, e.ir);
      end
      if (partial !== e.part) begin
        tests_failed++;
        $display("FAIL partial @%0t: got %b expected %b", $time, partial, e.part);
      end
      if (out_valid_s !== e.ov || in_ready_s !== e.ir || partial_s !== e.part) begin
        tests_failed++;
        $display("FAIL sat_instance @%0t: got ov=%h ir=%b p=%b expected ov=%h ir=%b p=%b",
                 $time, out_valid_s, in_ready_s, partial_s, e.ov, e.ir, e.part);
      end
    end
  end

  // Inputs must already be driven; queues the expectation and advances one cycle.
  task automatic step(input logic [N-1:0] ov, input logic ir, input logic part);
    exp_t e;
    e.ov = ov; e.ir = ir; e.part = part;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    in_valid   = 1'b0;
    flush      = 1'b0;
    ASYNCRESET = 1'b1;
    #2;
    ASYNCRESET = 1'b0;
    #1;
  endtask

  task automatic check_counts(input string tag, input logic [15:0] tok, input logic [15:0] stl,
                              input logic part);
    tests_run += 3;
    if (tok_cnt !== tok) begin
      tests_failed++;
      $display("FAIL %s tok_cnt: got %0d expected %0d", tag, tok_cnt, tok);
    end
    if (stall_cnt !== stl) begin
      tests_failed++;
      $display("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, stl);
    end
    if (partial !== part) begin
      tests_failed++;
      $display("FAIL %s partial: got %b expected %b", tag, partial, part);
    end
  endtask

  task automatic test_reset();
    ASYNCRESET = 1'b1;
    in_valid   = 1'b1;
    flush      = 1'b0;
    en         = '1;
    sel        = '1;
    out_ready  = '1;
    repeat (2) @(posedge CLK);
    #1;
    tests_run++;
    if (out_valid !== '0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %h expected 000", out_valid);
    end
    check_counts("reset", 16'd0, 16'd0, 1'b0);
    ASYNCRESET = 1'b0;
    in_valid   = 1'b0;
    #1;
  endtask

  task automatic test_all_ready();
    apply_reset();
    en = '1; sel = '1; out_ready = '1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) step(9'h1FF, 1'b1, 1'b0);
    in_valid = 1'b0;
    check_counts("all_ready", 16'd4, 16'd0, 1'b0);
  endtask

  task automatic test_staggered();
    apply_reset();
    en = '1; sel = 9'h007; in_valid = 1'b1;
    out_ready = 9'h001; step(9'h007, 1'b0, 1'b0);
    out_ready = 9'h002; step(9'h006, 1'b0, 1'b1);
    out_ready = 9'h004; step(9'h004, 1'b1, 1'b1);
    in_valid = 1'b0;
    check_counts("staggered", 16'd1, 16'd2, 1'b0);
  endtask

  task automatic test_no_target();
    apply_reset();
    en = '0; sel = '1; out_ready = '0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step(9'h000, 1'b1, 1'b0);
    in_valid = 1'b0;
    check_counts("no_target", 16'd3, 16'd0, 1'b0);
  endtask

  task automatic test_flush_and_reset();
    apply_reset();
    en = '1; sel = 9'h007; in_valid = 1'b1;
    out_ready = 9'h003; step(9'h007, 1'b0, 1'b0);
    check_counts("pre_flush", 16'd0, 16'd1, 1'b1);
    flush = 1'b1; out_ready = 9'h004; step(9'h000, 1'b0, 1'b1);
    flush = 1'b0;
    check_counts("flush", 16'd0, 16'd1, 1'b0);
    // All three targets offered again proves done was cleared by the flush.
    out_ready = 9'h000; step(9'h007, 1'b0, 1'b0);
    out_ready = 9'h003; step(9'h007, 1'b0, 1'b0);
    check_counts("pre_reset", 16'd0, 16'd3, 1'b1);
    ASYNCRESET = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_token out_valid: got %h expected 000", out_valid);
    end
    check_counts("reset_mid_token", 16'd0, 16'd0, 1'b0);
    ASYNCRESET = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 9'h007) begin
      tests_failed++;
      $display("FAIL reoffer out_valid: got %h expected 007", out_valid);
    end
    out_ready = 9'h007; step(9'h007, 1'b1, 1'b0);
    in_valid = 1'b0;
    check_counts("after_reset", 16'd1, 16'd0, 1'b0);
  endtask

  task automatic test_deselect();
    apply_reset();
    en = '1; sel = 9'h003; in_valid = 1'b1;
    out_ready = 9'h001; step(9'h003, 1'b0, 1'b0);
    sel = 9'h001; out_ready = 9'h000; step(9'h000, 1'b1, 1'b1);
    in_valid = 1'b0;
    check_counts("deselect", 16'd1, 16'd1, 1'b0);
  endtask

  task automatic test_new_select();
    apply_reset();
    en = '1; sel = 9'h003; in_valid = 1'b1;
    out_ready = 9'h001; step(9'h003, 1'b0, 1'b0);
    sel = 9'h007; out_ready = 9'h000; step(9'h006, 1'b0, 1'b1);
    out_ready = 9'h006; step(9'h006, 1'b1, 1'b1);
    in_valid = 1'b0;
    check_counts("new_select", 16'd1, 16'd2, 1'b0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    en = '1; sel = 9'h00F; in_valid = 1'b1;
    out_ready = 9'h00F; step(9'h00F, 1'b1, 1'b0);
    out_ready = 9'h005; step(9'h00F, 1'b0, 1'b0);
    out_ready = 9'h00A; step(9'h00A, 1'b1, 1'b1);
    out_ready = 9'h00F; step(9'h00F, 1'b1, 1'b0);
    in_valid = 1'b0;
    check_counts("back_to_back", 16'd3, 16'd1, 1'b0);
  endtask

  task automatic test_saturation();
    apply_reset();
    en = '1; sel = 9'h001; out_ready = '0; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) step(9'h001, 1'b0, 1'b0);
    tests_run += 2;
    if (stall_cnt_s !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_stall: got %0d expected 15", stall_cnt_s);
    end
    if (tok_cnt_s !== 4'd0) begin
      tests_failed++;
      $display("FAIL sat_tok: got %0d expected 0", tok_cnt_s);
    end
    check_counts("wide_stall", 16'd0, 16'd20, 1'b0);
    for (int i = 0; i < 2; i++) step(9'h001, 1'b0, 1'b0);
    in_valid = 1'b0;
    tests_run++;
    if (stall_cnt_s !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_hold: got %0d expected 15", stall_cnt_s);
    end
  endtask

  initial begin
    test_reset();
    test_all_ready();
    test_staggered();
    test_no_target();
    test_flush_and_reset();
    test_deselect();
    test_new_select();
    test_back_to_back();
    test_saturation();
    @(negedge CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
